// File: rtl/adder_self_checker.sv
// Built-in self-test sequencer for a 1-bit add/subtract cell: walks all 16
// {Ctrl,Cin,A,B} vectors, compares the cell against a golden model, reports errors.
//
// state  | meaning
// s_idle | waiting for start, operands driven 0
// s_settle | vector applied, waiting SETTLE cycles for the cell to settle
// s_check  | one-cycle compare of Sum/Cout against the golden model
// s_done   | run complete, results held until the next start
module adder_self_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       Cin,
  output logic       Ctrl,
  input  logic       Sum,
  input  logic       Cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] fail_index
);

  typedef enum logic [1:0] {s_idle, s_settle, s_check, s_done} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  state_t     state, state_nxt;
  logic [3:0] idx;
  logic [3:0] wait_cnt;
  logic       accept;
  logic       last_vec;
  logic       bx, sum_exp, cout_exp, mismatch;

  assign accept   = start && (state == s_idle || state == s_done);
  assign last_vec = (idx == 4'd15);

  // golden model evaluated on the registered operands, i.e. the applied vector
  assign bx       = B ^ Ctrl;
  assign sum_exp  = A ^ bx ^ Cin;
  assign cout_exp = (A & bx) | (A & Cin) | (bx & Cin);
  assign mismatch = (Sum != sum_exp) || (Cout != cout_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= s_idle;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      s_idle, s_done: if (accept) state_nxt = s_settle;
      s_settle:       if (wait_cnt == 4'd1) state_nxt = s_check;
      s_check:        state_nxt = last_vec ? s_done : s_settle;
      default:        state_nxt = s_idle;
    endcase
  end

  always_comb begin
    busy = (state == s_settle) || (state == s_check);
    done = (state == s_done);
    pass = done && (err_count == 5'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx                 <= 4'd0;
      wait_cnt            <= 4'd0;
      err_count           <= 5'd0;
      fail_index          <= 4'd0;
      {Ctrl, Cin, A, B}   <= 4'd0;
    end else begin
      case (state)
        s_idle, s_done: begin
          if (accept) begin
            idx               <= 4'd0;
            wait_cnt          <= SETTLE_LD;
            err_count         <= 5'd0;
            fail_index        <= 4'd0;
            {Ctrl, Cin, A, B} <= 4'd0;
          end
        end
        s_settle: wait_cnt <= wait_cnt - 4'd1;
        s_check: begin
          if (mismatch) begin
            err_count <= err_count + 5'd1;
            if (err_count == 5'd0) fail_index <= idx;
          end
          if (last_vec) begin
            {Ctrl, Cin, A, B} <= 4'd0;
          end else begin
            idx               <= idx + 4'd1;
            wait_cnt          <= SETTLE_LD;
            {Ctrl, Cin, A, B} <= idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_self_checker.sv
// Directed bench: behavioural add/sub cell with selectable faults drives the checker;
// expected results are hand-derived counts over the 16 vectors.
module tb_adder_self_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       A, B, Cin, Ctrl;
  logic       Sum, Cout;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic [3:0] fail_index;

  // 0 = correct cell, 1 = Sum stuck at 0, 2 = ignores Ctrl (always adds)
  int mode;
  int total = 0;
  int bad = 0;

  adder_self_checker #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A(A), .B(B), .Cin(Cin), .Ctrl(Ctrl),
    .Sum(Sum), .Cout(Cout),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_index(fail_index)
  );

  always #5 clk = ~clk;

  logic m_bx, m_s;
  always_comb begin
    m_bx = (mode == 2) ? B : (B ^ Ctrl);
    m_s  = A ^ m_bx ^ Cin;
    Sum  = (mode == 1) ? 1'b0 : m_s;
    Cout = (A & m_bx) | (A & Cin) | (m_bx & Cin);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // pulse start, then count edges until done; optional second start at edge restart_at
  task automatic run(input int restart_at, output int n, output bit busy_ok, output bit vec_ok);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0; busy_ok = 1'b1; vec_ok = 1'b1;
    if (!busy || {Ctrl, Cin, A, B} != 4'd0) begin busy_ok = 1'b0; vec_ok = 1'b0; end
    do begin
      @(posedge clk); #1;
      n++;
      start = (n == restart_at);
      if (!done) begin
        if (!busy) busy_ok = 1'b0;
        if ({Ctrl, Cin, A, B} != 4'(n / 3)) vec_ok = 1'b0;
      end
    end while (!done && n < 200);
    start = 1'b0;
  endtask

  int  n;
  bit  bok, vok;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fidx", fail_index, 0);
    chk("rst_vec", {Ctrl, Cin, A, B}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("idle_nostart", {busy, done}, 0);

    mode = 0;
    run(0, n, bok, vok);
    chk("good_latency", n, 48);
    chk("good_busy", bok, 1);
    chk("good_vectors", vok, 1);
    chk("good_done", done, 1);
    chk("good_busy_end", busy, 0);
    chk("good_pass", pass, 1);
    chk("good_err", err_count, 0);

    mode = 1;
    run(0, n, bok, vok);
    chk("stuck_latency", n, 48);
    chk("stuck_err", err_count, 8);
    chk("stuck_fidx", fail_index, 1);
    chk("stuck_pass", pass, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_err", err_count, 8);
    chk("hold_fidx", fail_index, 1);
    chk("hold_done", done, 1);
    chk("hold_vec", {Ctrl, Cin, A, B}, 0);

    mode = 0;
    run(0, n, bok, vok);
    chk("b2b_latency", n, 48);
    chk("b2b_err", err_count, 0);
    chk("b2b_fidx", fail_index, 0);
    chk("b2b_pass", pass, 1);

    mode = 2;
    run(0, n, bok, vok);
    chk("noctrl_err", err_count, 8);
    chk("noctrl_fidx", fail_index, 8);
    chk("noctrl_pass", pass, 0);

    mode = 0;
    run(10, n, bok, vok);
    chk("restart_latency", n, 48);
    chk("restart_busy", bok, 1);
    chk("restart_pass", pass, 1);

    // abort a failing run at cycle 20: vectors 0..5 checked, 1/2/4 mismatch
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("mid_err", err_count, 3);
    chk("mid_vec", {Ctrl, Cin, A, B}, 6);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", {done, pass}, 0);
    chk("arst_err", err_count, 0);
    chk("arst_fidx", fail_index, 0);
    chk("arst_vec", {Ctrl, Cin, A, B}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (60) @(posedge clk);
    #1 chk("post_rst_idle", {busy, done, pass}, 0);
    chk("post_rst_err", err_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_self_checker.md
ADDER_SELF_CHECKER -- requirements
Module: adder_self_checker

Interface
REQ-001 Parameter: SETTLE, default 2, cycles to hold each vector before sampling (legal range 1..15).
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  run request, sampled on rising clk.
REQ-005 A  output  1  operand A driven to the adder under test.
REQ-006 B  output  1  operand B driven to the adder under test.
REQ-007 Cin  output  1  carry-in driven to the adder under test.
REQ-008 Ctrl  output  1  mode to the adder under test; 0 = add, 1 = subtract (B inverted).
REQ-009 Sum  input  1  sum returned by the adder under test.
REQ-010 Cout  input  1  carry-out returned by the adder under test.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  high from run completion until the next accepted start.
REQ-013 pass  output  1  high when done=1 and err_count=0.
REQ-014 err_count  output  5  number of mismatching vectors in the last run (0..16).
REQ-015 fail_index  output  4  index of the first mismatching vector; meaningful only when err_count>0.

Function
REQ-016 The block SHALL have states IDLE, SETTLE, CHECK and DONE.
REQ-017 Vector index idx is 4 bits; applied vector SHALL be Ctrl=idx[3], Cin=idx[2], A=idx[1], B=idx[0].
REQ-018 In IDLE and DONE, A/B/Cin/Ctrl SHALL be driven 0.
REQ-019 start=1 in IDLE or DONE SHALL, on that edge: set idx=0, clear err_count, fail_index and done, load the wait counter with SETTLE, and enter SETTLE.
REQ-020 start while in SETTLE or CHECK SHALL be ignored.
REQ-021 A/B/Cin/Ctrl SHALL be registered outputs, stable for the whole SETTLE plus CHECK span of each vector.
REQ-022 SETTLE SHALL last exactly SETTLE cycles, then enter CHECK.
REQ-023 CHECK SHALL last one cycle and compare Sum/Cout against the golden model: Bx=B^Ctrl; Sum_exp=A^Bx^Cin; Cout_exp=(A&Bx)|(A&Cin)|(Bx&Cin).
REQ-024 A vector mismatches if Sum≠Sum_exp or Cout≠Cout_exp; each mismatching vector adds exactly 1 to err_count, even when both outputs mismatch.
REQ-025 On the first mismatch of a run, fail_index SHALL capture idx; later mismatches SHALL NOT change it.
REQ-026 CHECK with idx<15 SHALL increment idx, reload the wait counter and return to SETTLE.
REQ-027 CHECK with idx=15 SHALL enter DONE with done=1; idx does not wrap.
REQ-028 A full run SHALL take 16*(SETTLE+1) cycles from the start-accept edge to done=1 (48 for SETTLE=2).
REQ-029 busy SHALL be 1 exactly in SETTLE and CHECK.
REQ-030 err_count and fail_index SHALL hold their values in DONE until the next accepted start.
REQ-031 err_count cannot exceed 16; no saturation logic is needed.

Reset
REQ-032 rst=1 SHALL asynchronously force IDLE, idx=0, wait counter=0, A=B=Cin=Ctrl=0, busy=0, done=0, pass=0, err_count=0, fail_index=0.
REQ-033 rst asserted mid-run SHALL abort the run with no partial results retained; after rst release, start is required to begin a new run.

Verification
REQ-034 Correct add/sub cell model, SETTLE=2, start pulse -> busy for 48 cycles, then done=1, pass=1, err_count=0.
REQ-035 Sum stuck-at-0 model -> err_count=8, fail_index=1, pass=0.
REQ-036 Model ignoring Ctrl (always add) -> err_count=8, fail_index=8.
REQ-037 Second start pulse 10 cycles into a run -> no restart; done rises at cycle 48 of the first run.
REQ-038 rst pulse at cycle 20 of a run -> all outputs 0 immediately (asynchronously); after release the block stays in IDLE until start.
REQ-039 Back-to-back runs: failing model, then correct model with start in DONE -> second run reports err_count=0, pass=1, with no carry-over from the first run.
